int_calc_seq: RTL and testbench
===============================

// Module: int_calc_seq
// PURPOSE
//  Parametrised multi-cycle unsigned integer calculator; next generation of the 16-bit calculator.
//  Adds a valid/ready handshake with a one-cycle done pulse, iterative mul/div/mod/pow/isqrt
//  datapaths, and overflow/error flags. Sits between the command decoder and the display/result register.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be even and >= 4
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  enable     in   1      request valid; accepted on a clk edge where enable && ready
//  operation  in   3      0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 pow (A^B), 6 ilog2(A), 7 isqrt(A)
//  A          in   WIDTH  operand A, unsigned
//  B          in   WIDTH  operand B, unsigned; ignored by ops 6 and 7
//  ready      out  1      high in IDLE and DONE; low in CALC
//  done       out  1      one-cycle pulse; result and flags are valid from this cycle onward
//  sum        out  WIDTH  result
//  sign       out  1      sub only: 1 when A < B
//  overflow   out  1      true result does not fit in WIDTH bits
//  err        out  1      divide/mod by zero, or ilog2(0)
// BEHAVIOUR
//  - Reset: state=IDLE; sum=0, sign=0, overflow=0, err=0, done=0, ready=1.
//  - FSM IDLE -> (accept, op 0/1/6) -> DONE; IDLE -> (accept, op 2-5,7) -> CALC.
//    CALC -> (iteration count reaches N) -> DONE. DONE -> IDLE, or DONE -> CALC/DONE on a new accept.
//  - Accept: operation, A and B are registered. Input changes after accept do not affect the result.
//  - enable while ready=0 is ignored; no queuing.
//  - Latency, counted from the accept edge: ops 0/1/6 assert done 1 cycle later.
//    Ops 2-5 assert done WIDTH+1 cycles later; op 7 asserts done WIDTH/2+1 cycles later.
//  - sum/sign/overflow/err hold their values after done until the next done. They are updated only at done.
//  - add: sum = (A+B) mod 2^WIDTH; overflow = carry out.
//  - sub: sum = |A-B|; sign = (A<B); overflow = 0.
//  - mul: shift-add, one multiplier bit per cycle. sum = low WIDTH bits; overflow = any high product bit set.
//  - div/mod: restoring division, one quotient bit per cycle. div -> quotient, mod -> remainder.
//  - B==0: err=1, no iterations skipped (latency unchanged). div gives sum = all-ones; mod gives sum = A.
//  - pow: square-and-multiply, LSB-first, one exponent bit per cycle. Squaring/multiply use a WIDTH x WIDTH product truncated to WIDTH.
//    overflow is sticky if any product that contributes to the result exceeds WIDTH bits. A^0 = 1, including 0^0.
//  - ilog2: sum = floor(log2 A) (index of highest set bit). A==0: sum=0, err=1.
//  - isqrt: digit-by-digit, 2 bits per cycle; sum = floor(sqrt A).
//  - sign/overflow/err are cleared at done for every op that does not set them.
//  - rst mid-operation: abort immediately to the reset state; no done pulse for the aborted op.
//  - Simultaneous rst and enable: rst wins; the request is not accepted.
//  - done and ready are both high in DONE, which allows back-to-back accepts (one op every N+1 cycles).
// TESTING
//  1. WIDTH=16: add 25+30 -> done 1 cycle after accept, sum=55, overflow=0.
//     Then sub 25-30 -> sum=5, sign=1. Then sub 20-5 -> sum=15, sign=0.
//  2. mul 4*5 -> ready low 16 cycles, done 17 cycles after accept, sum=20.
//     Then mul 300*300 -> sum=0x5F90, overflow=1.
//  3. div 10/2 -> sum=5. mod 10%3 -> sum=1. div 7/0 -> sum=0xFFFF, err=1. mod 7%0 -> sum=7, err=1.
//  4. pow 2^10 -> sum=1024, overflow=0. pow 300^3 -> overflow=1. pow 0^0 -> sum=1.
//     ilog2(1000) -> sum=9. ilog2(0) -> err=1. isqrt(1000) -> sum=31, done 9 cycles after accept.
//  5. Start mul; toggle A/B and enable mid-CALC (no effect, no second accept).
//     Pulse rst at cycle 5 -> all outputs 0, ready=1, no done pulse.
//  6. WIDTH=8: add 200+100 -> sum=44, overflow=1. div 255/16 -> sum=15, done 9 cycles after accept.
//     Back-to-back accept in DONE is taken.

Source files
------------

// File: rtl/int_calc_seq.sv
// int_calc_seq: multi-cycle unsigned calculator (add/sub/mul/div/mod/pow/ilog2/isqrt) with ready/done handshake
module int_calc_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             sign,
  output logic             overflow,
  output logic             err
);
  localparam int W = WIDTH;
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [2:0] op;
  logic [W-1:0] a, b, x, y, r, b_n, x_n, y_n, r_n, lg, s_sum, c_sum;
  logic [2*W-1:0] p, p_n, m1, m2;
  logic [W:0] t, add, rd;
  logic [W+1:0] qs, trial;
  logic [CW-1:0] cnt;
  logic f, ovf, f_n, ovf_n, go, simple, last, ge_d, ge_q, c_ovf, c_err;
  assign ready = state != CALC;
  assign go = enable && ready;
  assign simple = operation inside {3'd0, 3'd1, 3'd6};
  assign last = cnt == (op == 3'd7 ? CW'(W / 2 - 1) : CW'(W - 1));
  assign add = {1'b0, A} + {1'b0, B};
  always_comb begin
    lg = '0;
    for (int i = 0; i < W; i++) if (A[i]) lg = W'(i);
  end
  assign s_sum = operation == 3'd0 ? add[W-1:0] : operation == 3'd1 ? (A < B ? B - A : A - B) : lg;
  // mul: p = {partial high, remaining multiplier bits}, shifted right each step
  assign t = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, a} : '0);
  assign p_n = {t, p[W-1:1]};
  // div: dividend shifts out of x while quotient bits shift in
  assign rd = {r, x[W-1]};
  assign ge_d = rd >= {1'b0, b};
  // isqrt: two radicand bits per step, y holds the partial root
  assign qs = {r, x[W-1:W-2]};
  assign trial = {y, 2'b01};
  assign ge_q = qs >= trial;
  // pow: y is the running result, x the repeatedly squared base, f marks a base that no longer fits
  assign m1 = {{W{1'b0}}, y} * {{W{1'b0}}, x};
  assign m2 = {{W{1'b0}}, x} * {{W{1'b0}}, x};
  assign x_n = op == 3'd5 ? m2[W-1:0] : op == 3'd7 ? x << 2 : {x[W-2:0], ge_d};
  assign y_n = op == 3'd5 ? (b[0] ? m1[W-1:0] : y) : {y[W-2:0], ge_q};
  assign r_n = op == 3'd7 ? W'(ge_q ? qs - trial : qs) : W'(ge_d ? rd - {1'b0, b} : rd);
  assign b_n = op == 3'd5 ? b >> 1 : b;
  assign f_n = f | (|m2[2*W-1:W]);
  assign ovf_n = ovf | (b[0] & (f | (|m1[2*W-1:W])));
  assign c_sum = op == 3'd2 ? p_n[W-1:0] : op == 3'd3 ? x_n : op == 3'd4 ? r_n : y_n;
  assign c_ovf = op == 3'd2 ? (|p_n[2*W-1:W]) : (op == 3'd5 && ovf_n);
  assign c_err = (op == 3'd3 || op == 3'd4) && b == '0;
  always_comb begin
    state_n = go ? (simple ? DONE : CALC) : state == DONE ? IDLE : (state == CALC && last) ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done <= 1'b0;
      sum <= '0;
      sign <= 1'b0;
      overflow <= 1'b0;
      err <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      done <= go ? simple : (state == CALC && last);
      if (go) begin
        op <= operation;
        a <= A;
        b <= B;
        x <= A;
        y <= operation == 3'd5 ? W'(1) : '0;
        r <= '0;
        p <= {{W{1'b0}}, B};
        f <= 1'b0;
        ovf <= 1'b0;
        cnt <= '0;
        if (simple) begin
          sum <= s_sum;
          sign <= operation == 3'd1 && A < B;
          overflow <= operation == 3'd0 && add[W];
          err <= operation == 3'd6 && A == '0;
        end
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
        p <= p_n;
        x <= x_n;
        y <= y_n;
        r <= r_n;
        b <= b_n;
        f <= f_n;
        ovf <= ovf_n;
        if (last) begin
          sum <= c_sum;
          sign <= 1'b0;
          overflow <= c_ovf;
          err <= c_err;
        end
      end
    end
  end
endmodule

// File: tb/tb_int_calc_seq.sv
// tb_int_calc_seq: directed scoreboard bench for int_calc_seq at WIDTH=16 and WIDTH=8
module tb_int_calc_seq;
  typedef struct {
    logic [15:0] s;
    logic sg, ov, er;
    int lat, c;
  } exp_t;
  logic clk = 0, rst = 1;
  logic enable16 = 0, enable8 = 0;
  logic [2:0] operation16 = 0, operation8 = 0;
  logic [15:0] A16 = 0, B16 = 0, sum16;
  logic [7:0] A8 = 0, B8 = 0, sum8;
  logic ready16, done16, sign16, overflow16, err16;
  logic ready8, done8, sign8, overflow8, err8;
  int cyc = 0, errors = 0, checks = 0;
  exp_t q16[$], q8[$];
  exp_t m16, m8;

  int_calc_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .enable(enable16), .operation(operation16),
    .A(A16), .B(B16), .ready(ready16), .done(done16), .sum(sum16), .sign(sign16),
    .overflow(overflow16), .err(err16));
  int_calc_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .enable(enable8), .operation(operation8),
    .A(A8), .B(B8), .ready(ready8), .done(done8), .sum(sum8), .sign(sign8),
    .overflow(overflow8), .err(err8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done16) begin
      if (q16.size() == 0) check("done16_unexpected", 32'(done16), 0);
      else begin
        m16 = q16.pop_front();
        check("sum16", 32'(sum16), 32'(m16.s));
        check("sign16", 32'(sign16), 32'(m16.sg));
        check("ovf16", 32'(overflow16), 32'(m16.ov));
        check("err16", 32'(err16), 32'(m16.er));
        check("lat16", cyc - m16.c, m16.lat);
      end
    end
    if (!rst && done8) begin
      if (q8.size() == 0) check("done8_unexpected", 32'(done8), 0);
      else begin
        m8 = q8.pop_front();
        check("sum8", 32'(sum8), 32'(m8.s[7:0]));
        check("sign8", 32'(sign8), 32'(m8.sg));
        check("ovf8", 32'(overflow8), 32'(m8.ov));
        check("err8", 32'(err8), 32'(m8.er));
        check("lat8", cyc - m8.c, m8.lat);
      end
    end
  end

  task automatic issue16(input logic [2:0] o, input logic [15:0] a, b, s, input logic sg, ov, er, input int lat);
    int n = 0;
    @(negedge clk);
    while (!ready16 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready16) check("issue16_timeout", 32'(ready16), 1);
    operation16 = o; A16 = a; B16 = b; enable16 = 1;
    q16.push_back('{s, sg, ov, er, lat, cyc});
    @(posedge clk);
    #1 enable16 = 0; A16 = 16'($urandom); B16 = 16'($urandom);
  endtask

  task automatic issue8(input bit now, input logic [2:0] o, input logic [7:0] a, b, s, input logic sg, ov, er, input int lat);
    int n = 0;
    if (!now) @(negedge clk);
    while (!ready8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready8) check("issue8_timeout", 32'(ready8), 1);
    operation8 = o; A8 = a; B8 = b; enable8 = 1;
    q8.push_back('{{8'h0, s}, sg, ov, er, lat, cyc});
    @(posedge clk);
    #1 enable8 = 0; A8 = 8'($urandom); B8 = 8'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((q16.size() != 0 || q8.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q16.size() != 0 || q8.size() != 0) check("drain_timeout", 32'(q16.size() + q8.size()), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    check("rst_sum", 32'(sum16), 0);
    check("rst_sign", 32'(sign16), 0);
    check("rst_ovf", 32'(overflow16), 0);
    check("rst_err", 32'(err16), 0);
    check("rst_done", 32'(done16), 0);
    check("rst_ready", 32'(ready16), 1);
    check("rst_ready8", 32'(ready8), 1);
    issue16(3'd0, 16'd25, 16'd30, 16'd55, 0, 0, 0, 1);
    issue16(3'd1, 16'd25, 16'd30, 16'd5, 1, 0, 0, 1);
    issue16(3'd1, 16'd20, 16'd5, 16'd15, 0, 0, 0, 1);
    issue16(3'd0, 16'hFFFF, 16'd2, 16'd1, 0, 1, 0, 1);
    issue16(3'd2, 16'd4, 16'd5, 16'd20, 0, 0, 0, 17);
    @(negedge clk);
    check("ready_low_calc", 32'(ready16), 0);
    issue16(3'd2, 16'd300, 16'd300, 16'h5F90, 0, 1, 0, 17);
    issue16(3'd3, 16'd10, 16'd2, 16'd5, 0, 0, 0, 17);
    issue16(3'd4, 16'd10, 16'd3, 16'd1, 0, 0, 0, 17);
    issue16(3'd3, 16'd7, 16'd0, 16'hFFFF, 0, 0, 1, 17);
    issue16(3'd4, 16'd7, 16'd0, 16'd7, 0, 0, 1, 17);
    issue16(3'd5, 16'd2, 16'd10, 16'd1024, 0, 0, 0, 17);
    issue16(3'd5, 16'd300, 16'd3, 16'hFCC0, 0, 1, 0, 17);
    issue16(3'd5, 16'd0, 16'd0, 16'd1, 0, 0, 0, 17);
    issue16(3'd6, 16'd1000, 16'd77, 16'd9, 0, 0, 0, 1);
    issue16(3'd6, 16'd0, 16'd0, 16'd0, 0, 0, 1, 1);
    issue16(3'd7, 16'd1000, 16'd5, 16'd31, 0, 0, 0, 9);
    issue16(3'd7, 16'hFFFF, 16'd0, 16'd255, 0, 0, 0, 9);
    // inputs and enable wiggle during CALC must be ignored
    issue16(3'd2, 16'd7, 16'd9, 16'd63, 0, 0, 0, 17);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      enable16 = 1; operation16 = 3'd0; A16 = 16'($urandom); B16 = 16'($urandom);
    end
    check("ready_low_toggle", 32'(ready16), 0);
    enable16 = 0;
    drain();
    // abort a multiply with reset, with enable raised alongside reset
    issue16(3'd2, 16'd11, 16'd13, 16'd143, 0, 0, 0, 17);
    repeat (4) @(negedge clk);
    rst = 1; enable16 = 1; operation16 = 3'd2;
    @(negedge clk);
    rst = 0; enable16 = 0;
    q16.delete();
    check("abort_sum", 32'(sum16), 0);
    check("abort_ovf", 32'(overflow16), 0);
    check("abort_err", 32'(err16), 0);
    check("abort_done", 32'(done16), 0);
    check("abort_ready", 32'(ready16), 1);
    repeat (25) @(negedge clk);
    check("abort_ready_later", 32'(ready16), 1);
    issue8(0, 3'd0, 8'd200, 8'd100, 8'd44, 0, 1, 0, 1);
    issue8(0, 3'd3, 8'd255, 8'd16, 8'd15, 0, 0, 0, 9);
    begin
      int n = 0;
      @(negedge clk);
      while (!done8 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("b2b_done", 32'(done8), 1);
      check("b2b_ready", 32'(ready8), 1);
    end
    issue8(1, 3'd2, 8'd15, 8'd17, 8'd255, 0, 0, 0, 9);
    issue8(0, 3'd1, 8'd3, 8'd10, 8'd7, 1, 0, 0, 1);
    drain();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
